pwm_multi_ctrl: RTL and testbench

Next-generation multi-channel PWM engine. It replaces the per-channel fixed-function controller array behind the UDP parameter parser. Its additions are:
- parametrised counter width and channel count
- per-channel phase offset and output polarity
- finite pulse-train mode
- group-synchronous start
- pending config held in shadow registers and applied only on period boundaries.

It sits directly downstream of the PWM parameter-frame parser and drives the board PWM pins.

---
 rtl/pwm_multi_pkg.sv | 31 +++
 rtl/pwm_multi_ctrl_chan.sv | 171 +++++++++++++++++
 rtl/pwm_multi_ctrl.sv | 90 +++++++++
 tb/tb_pwm_multi_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_multi_pkg.sv
// Shared definitions for the multi-channel PWM engine: channel state encoding
// and the layout of the per-channel configuration record.
package pwm_multi_pkg;

    typedef enum logic [1:0] {
        CH_IDLE  = 2'd0,
        CH_ARMED = 2'd1,
        CH_RUN   = 2'd2
    } chan_state_e;

    localparam int DEF_CNT_W   = 28;
    localparam int DEF_PULSE_W = 16;

    // Record is packed MSB-first as {en, sync, inv, period, hlevel, phase, pulses}.
    function automatic int cfg_width(input int cnt_w, input int pulse_w);
        return 3 + 3 * cnt_w + pulse_w;
    endfunction

    localparam int PWM_CFG_W = cfg_width(DEF_CNT_W, DEF_PULSE_W);

    typedef struct packed {
        logic                   en;
        logic                   sync;
        logic                   inv;
        logic [DEF_CNT_W-1:0]   period;
        logic [DEF_CNT_W-1:0]   hlevel;
        logic [DEF_CNT_W-1:0]   phase;
        logic [DEF_PULSE_W-1:0] pulses;
    } pwm_cfg_t;

endpackage

// File: rtl/pwm_multi_ctrl_chan.sv
// One PWM channel: pending/active config registers, IDLE/ARMED/RUN state
// machine, period counter and pulse-train tally.
module pwm_chan
    import pwm_multi_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int PULSE_W = DEF_PULSE_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr,
    input  logic               cfg_en,
    input  logic               cfg_sync,
    input  logic               cfg_inv,
    input  logic [CNT_W-1:0]   cfg_period,
    input  logic [CNT_W-1:0]   cfg_hlevel,
    input  logic [CNT_W-1:0]   cfg_phase,
    input  logic [PULSE_W-1:0] cfg_pulses,
    input  logic               sync_start,
    output logic               pwm,
    output logic               busy,
    output logic               done
);

    typedef struct packed {
        logic               en;
        logic               sync;
        logic               inv;
        logic [CNT_W-1:0]   period;
        logic [CNT_W-1:0]   hlevel;
        logic [CNT_W-1:0]   phase;
        logic [PULSE_W-1:0] pulses;
    } cfg_t;

    localparam logic [CNT_W-1:0]   ONE_C = 1;
    localparam logic [PULSE_W-1:0] ONE_P = 1;

    chan_state_e        state_q, state_d;
    cfg_t               pend_cfg_q, pend_cfg_d;
    cfg_t               act_cfg_q, act_cfg_d;
    logic               pend_q, pend_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PULSE_W-1:0] tally_q, tally_d;
    logic               pwm_q, pwm_d;
    logic               fin_q, fin_d;
    logic               done_q, done_d;

    cfg_t               new_cfg;
    logic               terminal;
    logic               apply;
    logic               runnable;
    logic [PULSE_W-1:0] tally_inc;

    // Phase only takes effect when it falls inside the period.
    function automatic logic [CNT_W-1:0] entry_cnt(input cfg_t c);
        return (c.phase < c.period) ? c.phase : '0;
    endfunction

    always_comb begin
        new_cfg.en     = cfg_en;
        new_cfg.sync   = cfg_sync;
        new_cfg.inv    = cfg_inv;
        new_cfg.period = cfg_period;
        new_cfg.hlevel = cfg_hlevel;
        new_cfg.phase  = cfg_phase;
        new_cfg.pulses = cfg_pulses;

        terminal  = (state_q == CH_RUN) && (cnt_q == act_cfg_q.period - ONE_C);
        apply     = pend_q && ((state_q != CH_RUN) || terminal);
        runnable  = pend_cfg_q.en && (pend_cfg_q.period != '0);
        tally_inc = tally_q + ONE_P;

        state_d    = state_q;
        pend_d     = pend_q;
        pend_cfg_d = pend_cfg_q;
        act_cfg_d  = act_cfg_q;
        cnt_d      = cnt_q;
        tally_d    = tally_q;
        fin_d      = 1'b0;
        done_d     = fin_q;

        if (apply) begin
            act_cfg_d = pend_cfg_q;
            pend_d    = 1'b0;
        end
        // A write in the same cycle as an apply stays pending for the next boundary.
        if (wr) begin
            pend_cfg_d = new_cfg;
            pend_d     = 1'b1;
        end

        unique case (state_q)
            CH_IDLE: begin
                cnt_d   = '0;
                tally_d = '0;
                if (apply && runnable) begin
                    if (pend_cfg_q.sync) begin
                        state_d = CH_ARMED;
                    end else begin
                        state_d = CH_RUN;
                        cnt_d   = entry_cnt(pend_cfg_q);
                    end
                end
            end
            CH_ARMED: begin
                if (apply) begin
                    if (!runnable) begin
                        state_d = CH_IDLE;
                    end else if (!pend_cfg_q.sync) begin
                        state_d = CH_RUN;
                        cnt_d   = entry_cnt(pend_cfg_q);
                    end
                end else if (sync_start) begin
                    state_d = CH_RUN;
                    cnt_d   = entry_cnt(act_cfg_q);
                end
            end
            CH_RUN: begin
                cnt_d = cnt_q + ONE_C;
                if (terminal) begin
                    cnt_d   = '0;
                    tally_d = tally_inc;
                    if (apply) begin
                        tally_d = '0;
                        if (!runnable) begin
                            state_d = CH_IDLE;
                        end
                    end else if ((act_cfg_q.pulses != '0) && (tally_inc == act_cfg_q.pulses)) begin
                        state_d = CH_IDLE;
                        fin_d   = 1'b1;
                    end
                end
            end
            default: state_d = CH_IDLE;
        endcase

        pwm_d = act_cfg_q.inv;
        if (state_q == CH_RUN) begin
            pwm_d = (cnt_q < act_cfg_q.hlevel) ^ act_cfg_q.inv;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= CH_IDLE;
            pend_q     <= 1'b0;
            pend_cfg_q <= '0;
            act_cfg_q  <= '0;
            cnt_q      <= '0;
            tally_q    <= '0;
            pwm_q      <= 1'b0;
            fin_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            pend_cfg_q <= pend_cfg_d;
            act_cfg_q  <= act_cfg_d;
            cnt_q      <= cnt_d;
            tally_q    <= tally_d;
            pwm_q      <= pwm_d;
            fin_q      <= fin_d;
            done_q     <= done_d;
        end
    end

    assign pwm  = pwm_q;
    assign busy = (state_q != CH_IDLE);
    assign done = done_q;

endmodule

// File: rtl/pwm_multi_ctrl.sv
// Multi-channel PWM engine top: registers and decodes incoming config writes,
// flags out-of-range channel indices, and hosts one pwm_chan per channel.
module pwm_multi_ctrl
    import pwm_multi_pkg::*;
#(
    parameter int CH_NUM  = 4,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int PULSE_W = DEF_PULSE_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_vld,
    input  logic [7:0]         cfg_channel,
    input  logic               cfg_en,
    input  logic               cfg_sync,
    input  logic               cfg_inv,
    input  logic [CNT_W-1:0]   cfg_period,
    input  logic [CNT_W-1:0]   cfg_hlevel,
    input  logic [CNT_W-1:0]   cfg_phase,
    input  logic [PULSE_W-1:0] cfg_pulses,
    input  logic               sync_start,
    output logic [CH_NUM-1:0]  pwm,
    output logic [CH_NUM-1:0]  busy,
    output logic [CH_NUM-1:0]  done,
    output logic               cfg_err
);

    localparam int         REC_W  = cfg_width(CNT_W, PULSE_W);
    localparam logic [8:0] CH_LIM = 9'(CH_NUM);

    logic [CH_NUM-1:0]  wr_q, wr_d;
    logic [REC_W-1:0]   cfg_rec_q, cfg_rec_d;
    logic               cfg_err_q, cfg_err_d;
    logic               in_range;

    logic               rec_en, rec_sync, rec_inv;
    logic [CNT_W-1:0]   rec_period, rec_hlevel, rec_phase;
    logic [PULSE_W-1:0] rec_pulses;

    always_comb begin
        in_range  = ({1'b0, cfg_channel} < CH_LIM);
        cfg_err_d = cfg_vld && !in_range;
        cfg_rec_d = cfg_rec_q;
        wr_d      = '0;
        if (cfg_vld && in_range) begin
            cfg_rec_d = {cfg_en, cfg_sync, cfg_inv, cfg_period, cfg_hlevel, cfg_phase, cfg_pulses};
        end
        for (int i = 0; i < CH_NUM; i++) begin
            wr_d[i] = cfg_vld && in_range && (cfg_channel == 8'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_q      <= '0;
            cfg_rec_q <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            wr_q      <= wr_d;
            cfg_rec_q <= cfg_rec_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign {rec_en, rec_sync, rec_inv, rec_period, rec_hlevel, rec_phase, rec_pulses} = cfg_rec_q;
    assign cfg_err = cfg_err_q;

    for (genvar g = 0; g < CH_NUM; g++) begin : g_chan
        pwm_chan #(
            .CNT_W   (CNT_W),
            .PULSE_W (PULSE_W)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .wr         (wr_q[g]),
            .cfg_en     (rec_en),
            .cfg_sync   (rec_sync),
            .cfg_inv    (rec_inv),
            .cfg_period (rec_period),
            .cfg_hlevel (rec_hlevel),
            .cfg_phase  (rec_phase),
            .cfg_pulses (rec_pulses),
            .sync_start (sync_start),
            .pwm        (pwm[g]),
            .busy       (busy[g]),
            .done       (done[g])
        );
    end

endmodule

// File: tb/tb_pwm_multi_ctrl.sv
// Directed bench for pwm_multi_ctrl: per-cycle output windows compared against
// hand-derived bit patterns (bit i-1 = sample taken just after edge k+i).
module tb_pwm_multi_ctrl;
    import pwm_multi_pkg::*;

    localparam int CH_NUM  = 4;
    localparam int CNT_W   = DEF_CNT_W;
    localparam int PULSE_W = DEF_PULSE_W;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               cfg_vld = 1'b0;
    logic [7:0]         cfg_channel = '0;
    logic               cfg_en = 1'b0;
    logic               cfg_sync = 1'b0;
    logic               cfg_inv = 1'b0;
    logic [CNT_W-1:0]   cfg_period = '0;
    logic [CNT_W-1:0]   cfg_hlevel = '0;
    logic [CNT_W-1:0]   cfg_phase = '0;
    logic [PULSE_W-1:0] cfg_pulses = '0;
    logic               sync_start = 1'b0;
    logic [CH_NUM-1:0]  pwm;
    logic [CH_NUM-1:0]  busy;
    logic [CH_NUM-1:0]  done;
    logic               cfg_err;

    always #5 clk = ~clk;

    pwm_multi_ctrl #(
        .CH_NUM  (CH_NUM),
        .CNT_W   (CNT_W),
        .PULSE_W (PULSE_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_vld     (cfg_vld),
        .cfg_channel (cfg_channel),
        .cfg_en      (cfg_en),
        .cfg_sync    (cfg_sync),
        .cfg_inv     (cfg_inv),
        .cfg_period  (cfg_period),
        .cfg_hlevel  (cfg_hlevel),
        .cfg_phase   (cfg_phase),
        .cfg_pulses  (cfg_pulses),
        .sync_start  (sync_start),
        .pwm         (pwm),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] cap_pwm  [CH_NUM];
    logic [63:0] cap_busy [CH_NUM];
    logic [63:0] cap_done [CH_NUM];
    int          cap_len;

    task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [63:0] ones(input int lo, input int hi);
        logic [63:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i-1] = 1'b1;
        return m;
    endfunction

    function automatic pwm_cfg_t mk_cfg(input logic en, input logic sync, input logic inv,
                                        input int per, input int hl, input int ph, input int pul);
        logic [PWM_CFG_W-1:0] raw;
        raw = {en, sync, inv, CNT_W'(per), CNT_W'(hl), CNT_W'(ph), PULSE_W'(pul)};
        return pwm_cfg_t'(raw);
    endfunction

    task automatic drive_cfg(input int ch, input pwm_cfg_t c);
        cfg_channel = 8'(ch);
        cfg_en      = c.en;
        cfg_sync    = c.sync;
        cfg_inv     = c.inv;
        cfg_period  = c.period;
        cfg_hlevel  = c.hlevel;
        cfg_phase   = c.phase;
        cfg_pulses  = c.pulses;
        cfg_vld     = 1'b1;
    endtask

    task automatic cfg_write(input int ch, input pwm_cfg_t c);
        drive_cfg(ch, c);
        step(1);
        cfg_vld = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step(2);
        rst = 1'b1;
        step(1);
    endtask

    task automatic rec_clear();
        cap_len = 0;
        for (int c = 0; c < CH_NUM; c++) begin
            cap_pwm[c]  = '0;
            cap_busy[c] = '0;
            cap_done[c] = '0;
        end
    endtask

    task automatic record(input int n);
        for (int i = 0; i < n; i++) begin
            step(1);
            for (int c = 0; c < CH_NUM; c++) begin
                cap_pwm[c][cap_len]  = pwm[c];
                cap_busy[c][cap_len] = busy[c];
                cap_done[c][cap_len] = done[c];
            end
            cap_len++;
        end
    endtask

    initial begin
        do_reset();
        chk_val("rst_pwm", 64'(pwm), 64'h0);
        chk_val("rst_busy", 64'(busy), 64'h0);
        chk_val("rst_done", 64'(done), 64'h0);
        chk_val("rst_err", 64'(cfg_err), 64'h0);

        // sync_start with nothing armed
        sync_start = 1'b1;
        step(1);
        sync_start = 1'b0;
        step(3);
        chk_val("nosync_busy", 64'(busy), 64'h0);

        // ch0 continuous 3/10
        cfg_write(0, mk_cfg(1, 0, 0, 10, 3, 0, 0));
        rec_clear();
        record(25);
        chk_val("ch0_pwm", cap_pwm[0], ones(3, 5) | ones(13, 15) | ones(23, 25));
        chk_val("ch0_busy", cap_busy[0], ones(2, 25));

        // ch1 rewrite mid-period: applies at the next boundary
        do_reset();
        cfg_write(1, mk_cfg(1, 0, 0, 10, 3, 0, 0));
        rec_clear();
        record(6);
        drive_cfg(1, mk_cfg(1, 0, 0, 20, 15, 0, 0));
        record(1);
        cfg_vld = 1'b0;
        record(43);
        chk_val("ch1_mid", cap_pwm[1], ones(3, 5) | ones(13, 27) | ones(33, 47));

        // ch1 rewrite landing on the terminal cycle waits one period
        do_reset();
        cfg_write(1, mk_cfg(1, 0, 0, 10, 3, 0, 0));
        rec_clear();
        record(10);
        drive_cfg(1, mk_cfg(1, 0, 0, 20, 15, 0, 0));
        record(1);
        cfg_vld = 1'b0;
        record(39);
        chk_val("ch1_term", cap_pwm[1], ones(3, 5) | ones(13, 15) | ones(23, 37) | ones(43, 50));

        // ch2 finite train of 3 periods
        do_reset();
        cfg_write(2, mk_cfg(1, 0, 0, 8, 4, 0, 3));
        rec_clear();
        record(40);
        chk_val("ch2_pwm", cap_pwm[2], ones(3, 6) | ones(11, 14) | ones(19, 22));
        chk_val("ch2_busy", cap_busy[2], ones(2, 25));
        chk_val("ch2_done", cap_done[2], ones(27, 27));

        // ch0/ch3 group start, 180 degrees apart
        do_reset();
        cfg_write(0, mk_cfg(1, 1, 0, 10, 5, 0, 0));
        cfg_write(3, mk_cfg(1, 1, 0, 10, 5, 5, 0));
        step(20);
        chk_val("armed_pwm", 64'(pwm), 64'h0);
        chk_val("armed_busy", 64'(busy), 64'h9);
        sync_start = 1'b1;
        step(1);
        sync_start = 1'b0;
        rec_clear();
        record(30);
        chk_val("sync_ch0", cap_pwm[0], ones(1, 5) | ones(11, 15) | ones(21, 25));
        chk_val("sync_ch3", cap_pwm[3], ones(6, 10) | ones(16, 20) | ones(26, 30));

        // sync_start coinciding with the apply into ARMED is ignored
        do_reset();
        cfg_write(2, mk_cfg(1, 1, 0, 4, 2, 0, 0));
        step(1);
        sync_start = 1'b1;
        step(1);
        sync_start = 1'b0;
        step(4);
        chk_val("coinc_busy", 64'(busy[2]), 64'h1);
        chk_val("coinc_pwm", 64'(pwm[2]), 64'h0);
        sync_start = 1'b1;
        step(1);
        sync_start = 1'b0;
        rec_clear();
        record(8);
        chk_val("coinc_run", cap_pwm[2], ones(1, 2) | ones(5, 6));

        // out-of-range channel
        do_reset();
        drive_cfg(7, mk_cfg(1, 0, 0, 10, 3, 0, 0));
        step(1);
        cfg_vld = 1'b0;
        chk_val("err_pulse", 64'(cfg_err), 64'h1);
        step(1);
        chk_val("err_clear", 64'(cfg_err), 64'h0);
        step(3);
        chk_val("err_busy", 64'(busy), 64'h0);

        // inverted 0% and clamped 100%
        cfg_write(1, mk_cfg(1, 0, 1, 10, 0, 0, 0));
        cfg_write(0, mk_cfg(1, 0, 0, 10, 12, 0, 0));
        rec_clear();
        record(25);
        chk_val("inv_zero", cap_pwm[1], ones(2, 25));
        chk_val("full_on", cap_pwm[0], ones(3, 25));

        // reset mid-period on all channels
        do_reset();
        cfg_write(0, mk_cfg(1, 0, 0, 10, 5, 0, 0));
        cfg_write(1, mk_cfg(1, 0, 1, 10, 5, 0, 0));
        cfg_write(2, mk_cfg(1, 0, 0, 10, 5, 0, 0));
        cfg_write(3, mk_cfg(1, 0, 0, 10, 5, 0, 0));
        step(7);
        chk_val("pre_rst_busy", 64'(busy), 64'hf);
        rst = 1'b0;
        step(1);
        chk_val("mid_rst_pwm", 64'(pwm), 64'h0);
        chk_val("mid_rst_busy", 64'(busy), 64'h0);
        rst = 1'b1;
        step(15);
        chk_val("post_rst_pwm", 64'(pwm), 64'h0);
        chk_val("post_rst_busy", 64'(busy), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
